// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the fetch/data RAM arbiter: FSM states, grant IDs and default widths.
// Pure declarations: no logic, no latency, no flow control.
package memory_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/memory_arbiter_if.sv
// Core-side fetch/data request ports plus RAM command/response signals of the arbiter.
// slave = arbiter view, master = core + RAM view.
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                    fetchReq;
    logic [31:0]             fetchAddr;
    logic [DATA_WIDTH-1:0]   fetchData;
    logic                    fetchValid;

    logic                    dataReq;
    logic                    dataWe;
    logic [31:0]             dataAddr;
    logic [DATA_WIDTH-1:0]   dataWdata;
    logic [DATA_WIDTH/8-1:0] dataWmask;
    logic [DATA_WIDTH-1:0]   dataRdata;
    logic                    dataValid;

    logic                    memEn;
    logic                    memWe;
    logic [DATA_WIDTH/8-1:0] memWmask;
    logic [ADDR_WIDTH-1:0]   memAddr;
    logic [DATA_WIDTH-1:0]   memWdata;
    logic [DATA_WIDTH-1:0]   memRdata;

    modport slave (
        input  fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWdata, dataWmask, memRdata,
        output fetchData, fetchValid, dataRdata, dataValid,
               memEn, memWe, memWmask, memAddr, memWdata
    );

    modport master (
        output fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWdata, dataWmask, memRdata,
        input  fetchData, fetchValid, dataRdata, dataValid,
               memEn, memWe, memWmask, memAddr, memWdata
    );

endinterface

// File: rtl/memory_arbiter_rr_pick2.sv
// Two-way round-robin picker: combinational winner from eligible bits, last grant held in a flop.
// Zero-latency pick; history only advances when the caller accepts the grant.
module rr_pick2
    import memory_arbiter_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] elig,
    input  logic       advance,
    output logic       winner,
    output logic       any
);
    logic last_q;
    logic last_d;

    always_comb begin
        any    = |elig;
        winner = GRANT_FETCH;
        if (&elig) begin
            winner = ~last_q;
        end else if (elig[GRANT_DATA]) begin
            winner = GRANT_DATA;
        end
        last_d = advance ? winner : last_q;
    end

    // Reset as if data won last, so fetch takes the first tie.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_q <= GRANT_DATA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port RAM between fetch and load/store ports; req seen -> valid pulse in 3 edges.
// Requesters hold req until their valid pulse; one access in flight, one grant per 3 cycles.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
    input  logic              CLK,
    input  logic              RESET,
    memory_arbiter_if.slave   bus
);
    localparam int MW = DATA_WIDTH / 8;

    logic [1:0]            state_q,      state_d;
    logic                  grant_q,      grant_d;
    logic                  store_q,      store_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic                  fetch_vld_q,  fetch_vld_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
    logic                  data_vld_q,   data_vld_d;
    logic                  mem_en_q,     mem_en_d;
    logic                  mem_we_q,     mem_we_d;
    logic [MW-1:0]         mem_wmask_q,  mem_wmask_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;

    logic [1:0] elig;
    logic       winner;
    logic       any;
    logic       advance;
    logic       unused_addr_bits;

    // A requester still holding req during its own valid cycle must not be re-granted.
    assign elig[GRANT_FETCH] = bus.fetchReq & ~fetch_vld_q;
    assign elig[GRANT_DATA]  = bus.dataReq  & ~data_vld_q;
    assign advance           = (state_q == ST_IDLE) & any;

    assign unused_addr_bits = ^{bus.fetchAddr[31:ADDR_WIDTH+2], bus.fetchAddr[1:0],
                                bus.dataAddr[31:ADDR_WIDTH+2],  bus.dataAddr[1:0]};

    rr_pick2 u_pick (
        .CLK     (CLK),
        .RESET   (RESET),
        .elig    (elig),
        .advance (advance),
        .winner  (winner),
        .any     (any)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        store_d      = store_q;
        fetch_data_d = fetch_data_q;
        fetch_vld_d  = 1'b0;
        data_rdata_d = data_rdata_q;
        data_vld_d   = 1'b0;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_wmask_d  = mem_wmask_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    grant_d     = winner;
                    store_d     = (winner == GRANT_DATA) & bus.dataWe;
                    mem_en_d    = 1'b1;
                    mem_we_d    = (winner == GRANT_DATA) & bus.dataWe;
                    mem_wmask_d = (winner == GRANT_DATA) ? bus.dataWmask : '0;
                    mem_addr_d  = (winner == GRANT_DATA) ? bus.dataAddr[ADDR_WIDTH+1:2]
                                                         : bus.fetchAddr[ADDR_WIDTH+1:2];
                    mem_wdata_d = bus.dataWdata;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_wmask_d = '0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (grant_q == GRANT_DATA) begin
                    data_vld_d = 1'b1;
                    if (!store_q) begin
                        data_rdata_d = bus.memRdata;
                    end
                end else begin
                    fetch_vld_d  = 1'b1;
                    fetch_data_d = bus.memRdata;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_FETCH;
            store_q      <= 1'b0;
            fetch_data_q <= '0;
            fetch_vld_q  <= 1'b0;
            data_rdata_q <= '0;
            data_vld_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wmask_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            store_q      <= store_d;
            fetch_data_q <= fetch_data_d;
            fetch_vld_q  <= fetch_vld_d;
            data_rdata_q <= data_rdata_d;
            data_vld_q   <= data_vld_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.fetchData  = fetch_data_q;
    assign bus.fetchValid = fetch_vld_q;
    assign bus.dataRdata  = data_rdata_q;
    assign bus.dataValid  = data_vld_q;
    assign bus.memEn      = mem_en_q;
    assign bus.memWe      = mem_we_q;
    assign bus.memWmask   = mem_wmask_q;
    assign bus.memAddr    = mem_addr_q;
    assign bus.memWdata   = mem_wdata_q;

endmodule
